// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store traffic onto one single-ported memory.
// One outstanding access at a time, with fetch anti-starvation and a latency timeout.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int unsigned STARVE_W = 4;
   localparam int unsigned TMO_W    = 8;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [31:0]         WORD_MASK  = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e              state_q, state_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic                i_rvalid_q, i_rvalid_d;
   logic [31:0]         i_rdata_q, i_rdata_d;
   logic                i_err_q, i_err_d;
   logic                d_rvalid_q, d_rvalid_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
   logic                d_err_q, d_err_d;
   logic                busy_q, busy_d;
   logic                finish_c;

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         i_rvalid_q   <= 1'b0;
         i_rdata_q    <= '0;
         i_err_q      <= 1'b0;
         d_rvalid_q   <= 1'b0;
         d_rdata_q    <= '0;
         d_err_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         i_rvalid_q   <= i_rvalid_d;
         i_rdata_q    <= i_rdata_d;
         i_err_q      <= i_err_d;
         d_rvalid_q   <= d_rvalid_d;
         d_rdata_q    <= d_rdata_d;
         d_err_q      <= d_err_d;
         busy_q       <= busy_d;
      end
   end

   // Arbitration, handshake sequencing and response generation
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      busy_d       = busy_q;
      i_rvalid_d   = 1'b0;
      i_rdata_d    = '0;
      i_err_d      = 1'b0;
      d_rvalid_d   = 1'b0;
      d_rdata_d    = '0;
      d_err_d      = 1'b0;
      i_gnt        = 1'b0;
      d_gnt        = 1'b0;
      finish_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (reset) begin
               if (i_req && (!d_req || starve_cnt_q == STARVE_MAX)) begin
                  i_gnt = 1'b1;
               end else if (d_req) begin
                  d_gnt = 1'b1;
               end
            end
            if (i_gnt) begin
               state_d      = BUSY_I;
               starve_cnt_d = '0;
               tmo_cnt_d    = '0;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = i_addr & WORD_MASK;
               mem_wdata_d  = '0;
               mem_be_d     = 4'hF;
               busy_d       = 1'b1;
            end else if (d_gnt) begin
               state_d      = BUSY_D;
               tmo_cnt_d    = '0;
               mem_req_d    = 1'b1;
               mem_we_d     = d_we;
               mem_addr_d   = d_addr & WORD_MASK;
               mem_wdata_d  = d_wdata;
               mem_be_d     = d_be;
               busy_d       = 1'b1;
               if (i_req && starve_cnt_q != STARVE_MAX) begin
                  starve_cnt_d = starve_cnt_q + STARVE_W'(1);
               end
            end
         end
         BUSY_I, BUSY_D: begin
            // A ready on the final timeout cycle still counts as a normal completion
            finish_c = mem_ready || (TIMEOUT != 0 && tmo_cnt_q == TMO_LAST);
            if (finish_c) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_be_d    = '0;
               busy_d      = 1'b0;
               if (state_q == BUSY_I) begin
                  i_rvalid_d = 1'b1;
                  i_err_d    = !mem_ready;
                  i_rdata_d  = mem_ready ? mem_rdata : '0;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_err_d    = !mem_ready;
                  d_rdata_d  = (mem_ready && !mem_we_q) ? mem_rdata : '0;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_rvalid  = i_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign i_err     = i_err_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign busy      = busy_q;

endmodule
